// File: rtl/assembly_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : assembly_sequencer_pkg / assembly_sequencer_if
// Description : Shared assembler-state type plus the bundled bus between the
//               two-pass assembly sequencer and its environment. The bus
//               carries three groups of signals:
//                 text BRAM : text_addr_out, text_data_in
//                 assembler : assembler_state, new_line, new_character,
//                             line_count, char_count, incoming_character,
//                             asm_instruction_in, asm_new_instruction_in,
//                             asm_error_in
//                 imem      : imem_we_out, imem_addr_out, imem_data_out
//               modport master = sequencer side, modport slave = environment
//               (text BRAM, assembler core, instruction memory).
// Revision    : 1.0 - initial release
// ============================================================================

package assembly_sequencer_pkg;
  typedef enum logic [1:0] {
    IDLE                = 2'd0,
    PC_MAPPING          = 2'd1,
    INSTRUCTION_MAPPING = 2'd2
  } assembler_state_t;
endpackage

interface assembly_sequencer_if #(
  parameter int CHAR_PER_LINE = 64,
  parameter int NUMBER_LINES  = 256
);
  import assembly_sequencer_pkg::*;

  localparam int LA = $clog2(NUMBER_LINES);
  localparam int LC = $clog2(CHAR_PER_LINE);

  // text BRAM
  logic [LA+LC-1:0]  text_addr_out;
  logic [7:0]        text_data_in;

  // assembler core
  assembler_state_t  assembler_state;
  logic              new_line;
  logic              new_character;
  logic [LA-1:0]     line_count;
  logic [LC-1:0]     char_count;
  logic [7:0]        incoming_character;
  logic [31:0]       asm_instruction_in;
  logic              asm_new_instruction_in;
  logic              asm_error_in;

  // instruction memory
  logic              imem_we_out;
  logic [LA-1:0]     imem_addr_out;
  logic [31:0]       imem_data_out;

  modport master (
    output text_addr_out,
    input  text_data_in,
    output assembler_state, new_line, new_character,
    output line_count, char_count, incoming_character,
    input  asm_instruction_in, asm_new_instruction_in, asm_error_in,
    output imem_we_out, imem_addr_out, imem_data_out
  );

  modport slave (
    input  text_addr_out,
    output text_data_in,
    input  assembler_state, new_line, new_character,
    input  line_count, char_count, incoming_character,
    output asm_instruction_in, asm_new_instruction_in, asm_error_in,
    input  imem_we_out, imem_addr_out, imem_data_out
  );
endinterface

`default_nettype wire

// File: rtl/assembly_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : assembly_sequencer
// Description : Two-pass sequencer for the assembler. On start it streams the
//               line-major source text BRAM into the assembler twice: pass 1
//               under PC_MAPPING (label table build), pass 2 under
//               INSTRUCTION_MAPPING, writing every emitted instruction into
//               instruction memory. Reports busy / done / error.
// Ports       : clk_in          system clock
//               rst_n_in        asynchronous active-low reset
//               start_in        1-cycle start pulse (honoured when not busy)
//               bus             assembly_sequencer_if.master (text BRAM,
//                               assembler core and imem signal groups)
//               busy_out        passes running
//               done_out        sticky: assembly completed cleanly
//               error_out       sticky: assembly aborted on error
//               error_line_out  line_count when the error was latched
//               inst_count_out  instructions written in pass 2
// Revision    : 1.0 - initial release
// ============================================================================

module assembly_sequencer
  import assembly_sequencer_pkg::*;
#(
  parameter int  CHAR_PER_LINE = 64,
  parameter int  NUMBER_LINES  = 256,
  parameter int  READ_LATENCY  = 2,
  parameter int  LINE_GAP      = 4,
  localparam int LA            = $clog2(NUMBER_LINES),
  localparam int LC            = $clog2(CHAR_PER_LINE)
) (
  input  wire logic            clk_in,
  input  wire logic            rst_n_in,
  input  wire logic            start_in,
  assembly_sequencer_if.master bus,
  output logic                 busy_out,
  output logic                 done_out,
  output logic                 error_out,
  output logic [LA-1:0]        error_line_out,
  output logic [LA:0]          inst_count_out
);

  // One counter serves both the read-latency hold and the inter-line gap.
  localparam int WAIT_MAX = (READ_LATENCY > LINE_GAP) ? READ_LATENCY : LINE_GAP;
  localparam int WW       = $clog2(WAIT_MAX + 1);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_LINE_START = 3'd1;
  localparam logic [2:0] S_FETCH      = 3'd2;
  localparam logic [2:0] S_EMIT       = 3'd3;
  localparam logic [2:0] S_GAP        = 3'd4;
  localparam logic [2:0] S_PASS_END   = 3'd5;
  localparam logic [2:0] S_DONE       = 3'd6;
  localparam logic [2:0] S_ERROR      = 3'd7;

  logic [2:0]        r_state;
  logic [2:0]        w_next_state;
  logic              r_pass2;
  logic [LA-1:0]     r_line;
  logic [LC-1:0]     r_char;
  logic [WW-1:0]     r_wait;
  logic [7:0]        r_char_data;
  logic              r_new_char;
  assembler_state_t  r_asm_state;
  logic              r_done;
  logic              r_error;
  logic [LA-1:0]     r_error_line;
  logic [LA:0]       r_inst_count;
  logic              r_imem_we;
  logic [LA-1:0]     r_imem_addr;
  logic [31:0]       r_imem_data;

  logic              w_idle_like;
  logic              w_busy;
  logic              w_start;
  logic              w_abort;
  logic              w_lat_done;
  logic              w_gap_done;
  logic              w_eop;
  logic              w_eol;
  logic              w_last_line;
  logic              w_capture;

  assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR);
  assign w_busy      = !w_idle_like;
  assign w_start     = start_in && w_idle_like;
  assign w_abort     = bus.asm_error_in && w_busy;
  assign w_lat_done  = (r_wait == WW'(READ_LATENCY - 1));
  assign w_gap_done  = (r_wait == WW'(LINE_GAP - 1));
  // A null byte only terminates the program when it opens a line.
  assign w_eop       = (bus.text_data_in == 8'h00) && (r_char == '0);
  assign w_eol       = (bus.text_data_in == 8'h0A) || (r_char == LC'(CHAR_PER_LINE - 1));
  assign w_last_line = (r_line == LA'(NUMBER_LINES - 1));
  // Pass-2 capture stays open through GAP/PASS_END so the assembler's drain
  // of the final line still lands in imem. Error wins over a same-cycle strobe.
  assign w_capture   = r_pass2 && w_busy && bus.asm_new_instruction_in && !bus.asm_error_in
                       && (r_inst_count < (LA+1)'(NUMBER_LINES));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    if (w_abort) begin
      w_next_state = S_ERROR;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: if (start_in) w_next_state = S_LINE_START;
        S_LINE_START:            w_next_state = S_FETCH;
        S_FETCH:                 if (w_lat_done) w_next_state = S_EMIT;
        S_EMIT: begin
          if (w_eop)      w_next_state = S_PASS_END;
          else if (w_eol) w_next_state = S_GAP;
          else            w_next_state = S_FETCH;
        end
        S_GAP:                   if (w_gap_done) w_next_state = w_last_line ? S_PASS_END : S_LINE_START;
        S_PASS_END:              w_next_state = r_pass2 ? S_DONE : S_LINE_START;
        default:                 w_next_state = S_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  always_comb begin
    bus.new_line      = (r_state == S_LINE_START);
    bus.text_addr_out = {r_line, r_char};
    busy_out          = w_busy;
  end

  assign bus.assembler_state    = r_asm_state;
  assign bus.new_character      = r_new_char;
  assign bus.line_count         = r_line;
  assign bus.char_count         = r_char;
  assign bus.incoming_character = r_char_data;
  assign bus.imem_we_out        = r_imem_we;
  assign bus.imem_addr_out      = r_imem_addr;
  assign bus.imem_data_out      = r_imem_data;
  assign done_out               = r_done;
  assign error_out              = r_error;
  assign error_line_out         = r_error_line;
  assign inst_count_out         = r_inst_count;

  // --------------------------------------------------------------------------
  // Datapath: counters, character presentation, capture, status
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_pass2      <= 1'b0;
      r_line       <= '0;
      r_char       <= '0;
      r_wait       <= '0;
      r_char_data  <= '0;
      r_new_char   <= 1'b0;
      r_asm_state  <= IDLE;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_error_line <= '0;
      r_inst_count <= '0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_data  <= '0;
    end else begin
      r_new_char <= 1'b0;
      r_imem_we  <= 1'b0;

      // Wait counter restarts on every state change and runs in FETCH/GAP.
      if (w_next_state != r_state)
        r_wait <= '0;
      else if ((r_state == S_FETCH) || (r_state == S_GAP))
        r_wait <= r_wait + WW'(1);

      if (w_start) begin
        r_pass2      <= 1'b0;
        r_line       <= '0;
        r_char       <= '0;
        r_asm_state  <= PC_MAPPING;
        r_done       <= 1'b0;
        r_error      <= 1'b0;
        r_error_line <= '0;
        r_inst_count <= '0;
        r_imem_addr  <= '0;
      end else if (w_abort) begin
        r_error      <= 1'b1;
        r_error_line <= r_line;
        r_asm_state  <= IDLE;
      end else begin
        case (r_state)
          S_EMIT: begin
            if (!w_eop) begin
              r_char_data <= bus.text_data_in;
              r_new_char  <= 1'b1;
              if (!w_eol) r_char <= r_char + LC'(1);
            end
          end
          S_GAP: begin
            if (w_gap_done) begin
              r_line <= r_line + LA'(1);
              r_char <= '0;
            end
          end
          S_PASS_END: begin
            if (!r_pass2) begin
              r_pass2     <= 1'b1;
              r_asm_state <= INSTRUCTION_MAPPING;
              r_line      <= '0;
              r_char      <= '0;
            end else begin
              r_asm_state <= IDLE;
              r_done      <= 1'b1;
            end
          end
          default: ;
        endcase
      end

      if (w_capture) begin
        r_imem_we    <= 1'b1;
        r_imem_addr  <= r_inst_count[LA-1:0];
        r_imem_data  <= bus.asm_instruction_in;
        r_inst_count <= r_inst_count + (LA+1)'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_assembly_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_assembly_sequencer
// Description : Self-checking bench for assembly_sequencer. A latency-2 BRAM
//               model holds the source text; a stub assembler answers every
//               newline of a table-marked line with an instruction strobe.
//               Expected characters and imem writes are queued when the
//               stimulus is set up/driven and popped as the DUT produces them.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_assembly_sequencer;
  import assembly_sequencer_pkg::*;

  localparam int CPL = 64;
  localparam int NL  = 256;
  localparam int RL  = 2;
  localparam int LG  = 4;
  localparam int LA  = 8;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, error;
  logic [LA-1:0] error_line;
  logic [LA:0]   inst_count;

  assembly_sequencer_if #(.CHAR_PER_LINE(CPL), .NUMBER_LINES(NL)) bus ();

  assembly_sequencer #(
    .CHAR_PER_LINE(CPL), .NUMBER_LINES(NL), .READ_LATENCY(RL), .LINE_GAP(LG)
  ) dut (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .bus(bus),
    .busy_out(busy), .done_out(done), .error_out(error),
    .error_line_out(error_line), .inst_count_out(inst_count)
  );

  always #5 clk = ~clk;

  // Text BRAM model, read latency RL
  logic [7:0] text_mem [0:NL*CPL-1];
  logic [7:0] rd_pipe [RL];
  always @(posedge clk) begin
    rd_pipe[0] <= text_mem[bus.text_addr_out];
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.text_data_in = rd_pipe[RL-1];

  typedef struct packed { logic [7:0] ch; logic pass2; } exp_char_t;
  exp_char_t   exp_chars [$];
  logic [63:0] exp_writes[$];
  exp_char_t   mon_e;
  logic [63:0] mon_w;

  int passes = 0, checks = 0;
  int nl_seen = 0, chars_seen = 0, writes_seen = 0, exp_nl = 0, exp_inst = 0;
  logic        line_valid [NL];
  logic [31:0] line_word  [NL];
  logic        err_arm  = 1'b0;
  int          err_line = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  // Output monitor / scoreboard consumer
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.new_line) nl_seen++;
      if (bus.new_character) begin
        chars_seen++;
        if (exp_chars.size() == 0) begin
          checks++;
          $error("FAIL extra_char: observed 0x%0h expected no character", bus.incoming_character);
        end else begin
          mon_e = exp_chars.pop_front();
          chk("char", 64'(bus.incoming_character), 64'(mon_e.ch));
          chk("char_pass", 64'(bus.assembler_state == INSTRUCTION_MAPPING), 64'(mon_e.pass2));
        end
      end
      if (bus.imem_we_out) begin
        writes_seen++;
        if (exp_writes.size() == 0) begin
          checks++;
          $error("FAIL extra_write: observed addr 0x%0h data 0x%0h expected no write",
                 bus.imem_addr_out, bus.imem_data_out);
        end else begin
          mon_w = exp_writes.pop_front();
          chk("imem_write", {24'd0, bus.imem_addr_out, bus.imem_data_out}, mon_w);
        end
      end
    end
  end

  // Stub assembler: strobes an instruction two cycles after a newline of a
  // table-marked line (in both passes); only pass-2 strobes are expected in imem.
  initial begin : fake_asm
    int          delay;
    logic [31:0] pend;
    logic        pend_p2;
    delay   = -1;
    pend    = '0;
    pend_p2 = 1'b0;
    bus.asm_new_instruction_in = 1'b0;
    bus.asm_error_in           = 1'b0;
    bus.asm_instruction_in     = '0;
    forever begin
      @(negedge clk);
      bus.asm_new_instruction_in = 1'b0;
      bus.asm_error_in           = 1'b0;
      if (!rst_n) begin
        delay = -1;
      end else begin
        if (delay == 0) begin
          bus.asm_new_instruction_in = 1'b1;
          bus.asm_instruction_in     = pend;
          if (pend_p2) begin
            exp_writes.push_back({24'd0, 8'(exp_inst), pend});
            exp_inst++;
          end
          delay = -1;
        end else if (delay > 0) begin
          delay--;
        end
        if (bus.new_character && bus.incoming_character == 8'h0A && line_valid[bus.line_count]) begin
          delay   = 1;
          pend    = line_word[bus.line_count];
          pend_p2 = (bus.assembler_state == INSTRUCTION_MAPPING);
        end
        if (err_arm && bus.new_line && bus.assembler_state == INSTRUCTION_MAPPING
            && int'(bus.line_count) == err_line) begin
          bus.asm_error_in = 1'b1;
          err_arm          = 1'b0;
        end
      end
    end
  end

  task automatic clear_prog();
    for (int i = 0; i < NL*CPL; i++) text_mem[i] = 8'h00;
    for (int l = 0; l < NL; l++) begin line_valid[l] = 1'b0; line_word[l] = '0; end
  endtask

  task automatic put_line(input int l, input string s, input logic v, input logic [31:0] w);
    for (int i = 0; i < s.len(); i++) text_mem[l*CPL+i] = s[i];
    line_valid[l] = v;
    line_word[l]  = w;
  endtask

  // Reference model of the character stream and new_line count of both passes
  task automatic build_expect();
    exp_char_t e;
    exp_chars.delete();
    exp_writes.delete();
    exp_inst = 0; nl_seen = 0; chars_seen = 0; writes_seen = 0; exp_nl = 0;
    for (int p = 0; p < 2; p++) begin
      for (int l = 0; l < NL; l++) begin
        exp_nl++;
        if (text_mem[l*CPL] == 8'h00) break;
        for (int c = 0; c < CPL; c++) begin
          e.ch    = text_mem[l*CPL+c];
          e.pass2 = (p == 1);
          exp_chars.push_back(e);
          if (e.ch == 8'h0A) break;
        end
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done || error) break;
    end
  endtask

  task automatic finish_checks(input string t, input logic [LA:0] n_inst);
    repeat (10) @(negedge clk);
    chk({t, "_done"}, 64'(done), 64'd1);
    chk({t, "_error"}, 64'(error), 64'd0);
    chk({t, "_busy"}, 64'(busy), 64'd0);
    chk({t, "_asm_state"}, 64'(bus.assembler_state), 64'(IDLE));
    chk({t, "_inst_count"}, 64'(inst_count), 64'(n_inst));
    chk({t, "_chars_left"}, 64'(exp_chars.size()), 64'd0);
    chk({t, "_writes_left"}, 64'(exp_writes.size()), 64'd0);
    chk({t, "_new_lines"}, 64'(nl_seen), 64'(exp_nl));
  endtask

  task automatic check_all_zero(input string t);
    chk({t, "_busy"}, 64'(busy), 64'd0);
    chk({t, "_done"}, 64'(done), 64'd0);
    chk({t, "_error"}, 64'(error), 64'd0);
    chk({t, "_error_line"}, 64'(error_line), 64'd0);
    chk({t, "_inst_count"}, 64'(inst_count), 64'd0);
    chk({t, "_asm_state"}, 64'(bus.assembler_state), 64'(IDLE));
    chk({t, "_strobes"}, {61'd0, bus.new_line, bus.new_character, bus.imem_we_out}, 64'd0);
    chk({t, "_counts"}, {42'd0, bus.line_count, bus.char_count, bus.text_addr_out}, 64'd0);
    chk({t, "_incoming"}, 64'(bus.incoming_character), 64'd0);
    chk({t, "_imem_bus"}, {24'd0, bus.imem_addr_out, bus.imem_data_out}, 64'd0);
  endtask

  initial begin : directed
    int n;
    clear_prog();
    // ---- reset state
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // ---- 1: single instruction + null line
    clear_prog();
    put_line(0, "addi x1, x0, 5\n", 1'b1, 32'h00500093);
    build_expect();
    pulse_start();
    chk("t1_busy_running", 64'(busy), 64'd1);
    wait_end(5000);
    finish_checks("t1", 9'd1);

    // ---- 2: label on line 0, backward branch on line 2
    clear_prog();
    put_line(0, "lbl:\n", 1'b0, 32'h0);
    put_line(1, "addi x1, x0, 5\n", 1'b1, 32'h00500093);
    put_line(2, "beq x0,x0,lbl\n", 1'b1, 32'hFE000EE3);
    build_expect();
    pulse_start();
    wait_end(5000);
    finish_checks("t2", 9'd2);

    // ---- 3: full 64-char line without newline
    clear_prog();
    for (int c = 0; c < CPL; c++) text_mem[c] = 8'h61 + 8'(c % 26);
    build_expect();
    pulse_start();
    n = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bus.new_character) begin
        n++;
        if (n == CPL) break;
      end
    end
    chk("t3_last_char_idx", 64'(bus.char_count), 64'd63);
    for (int k = 1; k <= LG; k++) begin
      @(negedge clk);
      chk("t3_new_line_after_gap", 64'(bus.new_line), 64'(k == LG));
    end
    chk("t3_line_count", 64'(bus.line_count), 64'd1);
    chk("t3_char_wrap", 64'(bus.char_count), 64'd0);
    wait_end(5000);
    finish_checks("t3", 9'd0);

    // ---- 4: error on line 2 of pass 2
    clear_prog();
    for (int l = 0; l < 4; l++) put_line(l, "addi x1, x0, 5\n", 1'b1, 32'h00000093 | (32'(l + 1) << 20));
    build_expect();
    err_line = 2;
    err_arm  = 1'b1;
    pulse_start();
    wait_end(5000);
    chk("t4_error", 64'(error), 64'd1);
    chk("t4_error_line", 64'(error_line), 64'd2);
    chk("t4_done", 64'(done), 64'd0);
    chk("t4_busy", 64'(busy), 64'd0);
    chk("t4_asm_state", 64'(bus.assembler_state), 64'(IDLE));
    n = chars_seen;
    repeat (40) @(negedge clk);
    chk("t4_writes", 64'(writes_seen), 64'd2);
    chk("t4_inst_count", 64'(inst_count), 64'd2);
    chk("t4_no_chars_after", 64'(chars_seen), 64'(n));
    chk("t4_writes_left", 64'(exp_writes.size()), 64'd0);

    // ---- 5a: start while busy is ignored
    clear_prog();
    put_line(0, "lbl:\n", 1'b0, 32'h0);
    put_line(1, "addi x1, x0, 5\n", 1'b1, 32'h00500093);
    put_line(2, "beq x0,x0,lbl\n", 1'b1, 32'hFE000EE3);
    build_expect();
    pulse_start();
    for (int i = 0; i < 500 && chars_seen < 8; i++) @(negedge clk);
    pulse_start();
    chk("t5_busy_kept", 64'(busy), 64'd1);
    chk("t5_state_kept", 64'(bus.assembler_state), 64'(PC_MAPPING));
    chk("t5_line_kept", 64'(bus.line_count), 64'd1);
    wait_end(5000);
    finish_checks("t5", 9'd2);

    // ---- 5b: asynchronous reset in the middle of pass 2
    build_expect();
    pulse_start();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus.assembler_state == INSTRUCTION_MAPPING && bus.line_count == 8'd1) break;
    end
    chk("t5_in_pass2", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("t5_async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ---- 6: empty program
    clear_prog();
    build_expect();
    pulse_start();
    wait_end(1000);
    finish_checks("t6", 9'd0);
    chk("t6_no_chars", 64'(chars_seen), 64'd0);

    // ---- 7: every line used, pass ends on the last line index
    clear_prog();
    for (int l = 0; l < NL; l++) put_line(l, "\n", 1'b0, 32'h0);
    build_expect();
    pulse_start();
    wait_end(10000);
    finish_checks("t7", 9'd0);
    chk("t7_chars", 64'(chars_seen), 64'(2 * NL));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
